serial_receiver: RTL and testbench

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver_pkg.sv | 23 ++
 rtl/rx_shift_core.sv | 46 ++++
 rtl/serial_receiver.sv | 111 +++++++++++
 tb/tb_serial_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_receiver_pkg
// Description : Shared types and constants for the serial word receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_receiver_pkg;

    localparam int c_WIDTH_DEFAULT = 8;
    localparam int c_CNT_W_DEFAULT = $clog2(c_WIDTH_DEFAULT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    // Bit counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : serial_receiver_pkg
`default_nettype wire

// File: rtl/rx_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : rx_shift_core
// Description : MSB-first shift register and bit counter; flags word completion.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_shift_core
    import serial_receiver_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_accept,
    input  logic             i_abort,
    input  logic             i_sin,
    output logic             o_done,
    output logic [WIDTH-1:0] o_word
);

    localparam int             CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    // Only WIDTH-1 bits are ever stored; the final bit is taken live from i_sin.
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_shift_next;

    assign w_shift_next = {r_shift, i_sin};
    assign o_word       = w_shift_next;
    assign o_done       = i_accept && (r_count == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_abort) begin
            r_count <= '0;
        end else if (i_accept) begin
            r_shift <= w_shift_next[WIDTH-2:0];
            r_count <= o_done ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule : rx_shift_core
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_receiver
// Description : Serial-to-parallel receiver with one-word output buffer,
//               valid/ready handshake and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic             w_accept;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_handshake;
    logic             w_overrun_set;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    assign w_accept = sin_valid && !abort;

    rx_shift_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_accept (w_accept),
        .i_abort  (abort),
        .i_sin    (sin),
        .o_done   (w_done),
        .o_word   (w_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (abort || w_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_handshake   = r_valid && out_ready;
    // A word finishing into a full, undrained buffer is lost.
    assign w_overrun_set = w_done && r_valid && !out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_done && (!r_valid || w_handshake)) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule : serial_receiver
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_receiver
// Description : Directed self-checking bench for serial_receiver (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_receiver;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             sin;
    logic             sin_valid;
    logic             abort;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             overrun_clr;

    int n_pass;
    int n_total;

    serial_receiver #(
        .WIDTH       (WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .abort       (abort),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] w3c;
        n_pass      = 0;
        n_total     = 0;
        reset_n     = 1'b0;
        sin         = 1'b0;
        sin_valid   = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        #2;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // 0xA5 on consecutive cycles, consumer always ready
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(a5[i]);
            if (i > 0) chk($sformatf("a5_busy_bit%0d", 8 - i), 32'(busy), 32'h1);
            if (i > 0) chk($sformatf("a5_novalid_bit%0d", 8 - i), 32'(out_valid), 32'h0);
        end
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_valid", 32'(out_valid), 32'h1);
        chk("a5_busy_done", 32'(busy), 32'h0);
        tick();
        chk("a5_valid_drained", 32'(out_valid), 32'h0);
        chk("a5_data_retained", 32'(data_out), 32'hA5);

        // 0x3C with idle gaps of 1..5 cycles between bits
        w3c = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w3c[i]);
            if (i > 0) begin
                repeat ((i % 5) + 1) tick();
                chk($sformatf("3c_busy_gap%0d", 8 - i), 32'(busy), 32'h1);
            end
        end
        chk("3c_data", 32'(data_out), 32'h3C);
        chk("3c_valid", 32'(out_valid), 32'h1);
        tick();

        // back-to-back words into a stalled consumer
        out_ready = 1'b0;
        send_word(8'h11);
        chk("ovr_first_valid", 32'(out_valid), 32'h1);
        chk("ovr_first_data", 32'(data_out), 32'h11);
        chk("ovr_first_flag", 32'(overrun), 32'h0);
        send_word(8'h22);
        chk("ovr_data_kept", 32'(data_out), 32'h11);
        chk("ovr_flag_set", 32'(overrun), 32'h1);
        chk("ovr_valid_kept", 32'(out_valid), 32'h1);
        tick();
        chk("ovr_sticky", 32'(overrun), 32'h1);
        // set and clear in the same cycle: set wins
        for (int i = 7; i >= 1; i--) send_bit(1'b0);
        overrun_clr = 1'b1;
        send_bit(1'b1);
        overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);
        chk("ovr_data_still", 32'(data_out), 32'h11);
        out_ready = 1'b1;
        tick();
        chk("ovr_drained", 32'(out_valid), 32'h0);

        // completion coincides with draining the previous word
        out_ready = 1'b0;
        send_word(8'h11);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        chk("same_hold_data", 32'(data_out), 32'h11);
        out_ready = 1'b1;
        send_bit(1'b0);
        chk("same_valid", 32'(out_valid), 32'h1);
        chk("same_data", 32'(data_out), 32'h22);
        chk("same_overrun", 32'(overrun), 32'h0);
        tick();
        chk("same_drained", 32'(out_valid), 32'h0);

        // abort mid-word, then a full word
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        abort     = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        tick();
        abort     = 1'b0;
        sin_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_valid", 32'(out_valid), 32'h0);
        chk("abort_data", 32'(data_out), 32'h22);
        out_ready = 1'b0;
        send_word(8'hF0);
        chk("abort_next_data", 32'(data_out), 32'hF0);
        chk("abort_next_valid", 32'(out_valid), 32'h1);

        // reset mid-word with buffer full and overrun set
        send_word(8'hFF);
        chk("pre_rst_overrun", 32'(overrun), 32'h1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send_bit(1'b1);
        chk("post_rst_busy", 32'(busy), 32'h1);
        for (int i = 6; i >= 1; i--) send_bit(1'b0);
        send_bit(1'b1);
        chk("post_rst_data", 32'(data_out), 32'h81);
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_receiver
`default_nettype wire
